add_round_key_stage: RTL and testbench
======================================

Name: add_round_key_stage

Overview:
- Registered AddRoundKey stage for the AES-128 encryption datapath. It sits directly downstream of the column-mixing stage.
- Each accepted 128-bit state is XORed with the current round key. The result is registered and presented on a valid/ready output.
- The round key is generated on the fly by an iterative key schedule. It advances one round per accepted block.
- Round 0 accepts plaintext, rounds 1-9 accept column-mixed state, and round 10 accepts the state from the final round (no column mix).

Parameters:
- NR, 10, number of rounds after the initial key addition (AES-128); the round counter spans 0..NR.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- key_load  in  1  single-cycle pulse; captures key_in as cipher key
- key_in  in  [0:127]  cipher key, bit 0 = MSB of byte 0
- in_valid  in  1  in_data valid
- in_ready  out  1  stage can accept in_data
- in_data  in  [0:127]  state to key (plaintext at round 0, mixed state otherwise)
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  [0:127]  in_data XOR round key
- out_round  out  4  round index (0..NR) of out_data
- out_last  out  1  high when out_round == NR

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - out_valid=0, out_data=0, out_round=0, out_last=0.
  - key_ok=0, round counter=0, cipher-key and round-key registers=0.
  - in_ready=0 while key_ok=0.
- Handshakes:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - in_ready = key_ok && !key_load && (!out_valid || out_ready).
  - out_data, out_round and out_last hold stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid. Full throughput of 1 block per cycle when out_ready is held high.
- Key load:
  - On key_load, cipher key and round key <= key_in, round <= 0, key_ok <= 1.
  - Any pending output is dropped (out_valid <= 0).
  - key_load has priority over a simultaneous input transfer; in_ready is forced low that cycle.
- Key schedule, on each input transfer at round r:
  - out_data <= in_data ^ rk, out_round <= r.
  - If r < NR, rk advances to round r+1 and round <= r+1:
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[r+1],24'h0}
    - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
    - w0 = rk[0:31], w3 = rk[96:127].
  - If r == NR (wrap-around), rk <= stored cipher key and round <= 0. The next block starts immediately with no reload required.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Reset mid-operation: all state returns to reset values and key_ok is cleared; a new key_load is required.
- A key_load during a stall (out_valid && !out_ready) discards the held output.

Optional Feature:
- Macro ARK_SKID_BUF_EN.
- Defined:
  - A 2-entry output skid buffer is added.
  - in_ready becomes registered: high when the buffer has at least one free entry, also subject to key_ok and !key_load.
  - Order is preserved.
  - key_load flushes both entries.
- Undefined: single output register; in_ready is combinational in out_ready as stated above.

Decomposition:
- Shared package (aes_pkg):
  - AES_NR = 10
  - Rcon constant table
  - 128-bit state/key typedef and 32-bit word typedef
  - the S-box lookup function
- Natural sub-module: key_expand_step. Combinational: takes rk and the round index, returns the next round key using 4 S-box lookups.
- The stage itself holds the FSM, counter, registers and handshake.

Test Plan:
- FIPS-197 round 0: key_load key 2b7e151628aed2a6abf7158809cf4f3c, input 3243f6a8885a308d313198a2e0370734 -> out_data 193de3bea0f4e22b9ac68d2ae9f84808, out_round 0, out_last 0.
- FIPS-197 round 1: input 046681e5e0cb199a48f8d37a2806264c -> out_data a49c7ff2689f352b6b5bea43026a5049, out_round 1. Internal rk check: round 1 key a0fafe1788542cb123a339392a6c7605.
- Full sequence: 11 blocks of zeros -> out_data equals each round key. Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with out_last 1. The 12th block yields 2b7e1516... at round 0 (wrap-around).
- Backpressure: hold out_ready=0 for 5 cycles mid-sequence -> out_data stable, in_ready 0, no round skipped. With ARK_SKID_BUF_EN, exactly 2 blocks are accepted before in_ready drops.
- key_load asserted together with in_valid at round 4 -> no transfer, out_valid drops, and the next block is keyed with the new round-0 key.
- rst_n low for 1 cycle mid-sequence -> all outputs 0, in_ready 0 until key_load.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-substitution helpers for the encryption datapath.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 4;

  typedef logic [0:BLK_W-1]  state_t;
  typedef logic [0:WORD_W-1] word_t;
  typedef logic [7:0]        byte_t;

  // Registered output payload: keyed state plus its round tag.
  typedef struct packed {
    state_t           data;
    logic [RND_W-1:0] round;
    logic             last;
  } ark_out_t;

  // Rcon[i] for i = 0..15; index 0 and 11..15 are unused padding.
  localparam logic [0:127] RCON_TBL = 128'h0001020408102040801b360000000000;

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic byte_t rcon(input logic [RND_W-1:0] i);
    return RCON_TBL[{i, 3'b000} +: 8];
  endfunction

  // SubWord(RotWord(w)).
  function automatic word_t sub_rot_word(input word_t w);
    return {sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31]), sbox(w[0:7])};
  endfunction

endpackage

// File: rtl/key_expand_step.sv
// One AES-128 key-schedule step: derives the round r+1 key from the round r key.
module key_expand_step
  import aes_pkg::*;
(
  input  logic [0:BLK_W-1] rk,
  input  logic [RND_W-1:0] round,
  output logic [0:BLK_W-1] rk_next_c
);

  logic [RND_W-1:0] round_inc;
  word_t            w0n, w1n, w2n, w3n;

  assign round_inc = round + RND_W'(1);

  always_comb begin
    w0n       = rk[0:31] ^ sub_rot_word(rk[96:127]) ^ {rcon(round_inc), 24'h000000};
    w1n       = rk[32:63] ^ w0n;
    w2n       = rk[64:95] ^ w1n;
    w3n       = rk[96:127] ^ w2n;
    rk_next_c = {w0n, w1n, w2n, w3n};
  end

endmodule

// File: rtl/add_round_key_stage.sv
// Registered AES-128 AddRoundKey stage with an on-the-fly iterative key schedule.
// Define ARK_SKID_BUF_EN to replace the single output register with a 2-entry skid buffer.
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [0:BLK_W-1] key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:BLK_W-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:BLK_W-1] out_data,
  output logic [RND_W-1:0] out_round,
  output logic             out_last
);

  typedef enum logic {ST_NOKEY, ST_KEYED} state_e;

  state_e           state_q, state_d;
  state_t           ckey_q, rk_q, rk_next_c;
  logic [RND_W-1:0] round_q;
  logic             key_ok, in_fire, round_last;
  ark_out_t         blk_d;

  assign key_ok     = (state_q == ST_KEYED);
  assign in_fire    = in_valid && in_ready;
  assign round_last = (round_q == RND_W'(NR));

  always_comb begin
    blk_d.data  = in_data ^ rk_q;
    blk_d.round = round_q;
    blk_d.last  = round_last;
  end

  key_expand_step u_key_expand_step (
    .rk        (rk_q),
    .round     (round_q),
    .rk_next_c (rk_next_c)
  );

  always_comb begin
    state_d = state_q;
    if (key_load) state_d = ST_KEYED;
  end

  // Key schedule advances once per accepted block and wraps back to the cipher key after round NR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_NOKEY;
      ckey_q  <= '0;
      rk_q    <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      if (key_load) begin
        ckey_q  <= key_in;
        rk_q    <= key_in;
        round_q <= '0;
      end else if (in_fire) begin
        if (round_last) begin
          rk_q    <= ckey_q;
          round_q <= '0;
        end else begin
          rk_q    <= rk_next_c;
          round_q <= round_q + RND_W'(1);
        end
      end
    end
  end

`ifdef ARK_SKID_BUF_EN

  ark_out_t   buf_q [2];
  logic       head_q, wr_idx, in_ready_q, pop;
  logic [1:0] cnt_q, cnt_d;

  assign pop       = out_valid && out_ready;
  assign wr_idx    = head_q ^ cnt_q[0];
  assign in_ready  = in_ready_q && !key_load;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf_q[head_q].data;
  assign out_round = buf_q[head_q].round;
  assign out_last  = buf_q[head_q].last;

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !in_fire) cnt_d = cnt_q - 2'd1;
  end

  // in_ready is precomputed from the next occupancy so it never depends on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q      <= '{default: '0};
      head_q     <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else if (key_load) begin
      head_q     <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      if (in_fire) buf_q[wr_idx] <= blk_d;
      if (pop)     head_q <= ~head_q;
      cnt_q      <= cnt_d;
      in_ready_q <= key_ok && (cnt_d != 2'd2);
    end
  end

`else

  ark_out_t out_q;
  logic     out_valid_q;

  assign in_ready  = key_ok && !key_load && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_round = out_q.round;
  assign out_last  = out_q.last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (key_load) begin
      out_valid_q <= 1'b0;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      out_q       <= blk_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed self-checking bench for add_round_key_stage using FIPS-197 key-schedule vectors.
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n, key_load, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [0:127] key_in, in_data, out_data;
  logic [3:0]   out_round;

  int total = 0;
  int bad   = 0;

`ifdef ARK_SKID_BUF_EN
  localparam int STALL_ACC = 2;
`else
  localparam int STALL_ACC = 1;
`endif

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] rk_tbl [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  always #5 clk = ~clk;

  add_round_key_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_round (out_round),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key_load = 1'b1;
    key_in   = k;
    @(posedge clk);
    #1 key_load = 1'b0;
  endtask

  // Transfers one block, then checks the registered result one cycle later.
  task automatic xfer(input logic [127:0] d, input logic [127:0] ed, input int er, input string tag);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check({tag, "_rdy_timeout"}, 128'(in_ready), 128'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_vld"}, 128'(out_valid), 128'(1));
    check({tag, "_dat"}, out_data, ed);
    check({tag, "_rnd"}, 128'(out_round), 128'(er));
    check({tag, "_lst"}, 128'(out_last), 128'(er == 10));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_vld"}, 128'(out_valid), 128'(0));
    check({tag, "_dat"}, out_data, 128'(0));
    check({tag, "_rnd"}, 128'(out_round), 128'(0));
    check({tag, "_lst"}, 128'(out_last), 128'(0));
    check({tag, "_rdy"}, 128'(in_ready), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int nxt;
    rst_n = 1'b0; key_load = 1'b0; key_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // FIPS-197 appendix B first two rounds
    load_key(KEY_A);
    @(negedge clk);
    check("keyed_rdy", 128'(in_ready), 128'(1));
    xfer(128'h3243f6a8885a308d313198a2e0370734, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, "fips_r0");
    check("rk1_internal", dut.rk_q, rk_tbl[1]);
    xfer(128'h046681e5e0cb199a48f8d37a2806264c, 128'ha49c7ff2689f352b6b5bea43026a5049, 1, "fips_r1");

    // Back-to-back zero blocks expose every round key, including the wrap to round 0
    load_key(KEY_A);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = '0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("seq%0d_rdy", i), 128'(in_ready), 128'(1));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("seq%0d_dat", i), out_data, rk_tbl[i % 11]);
      check($sformatf("seq%0d_rnd", i), 128'(out_round), 128'(i % 11));
      check($sformatf("seq%0d_lst", i), 128'(out_last), 128'((i % 11) == 10));
    end
    in_valid = 1'b0;

    // Backpressure at round 2
    load_key(KEY_A);
    xfer('0, rk_tbl[0], 0, "bp_r0");
    xfer('0, rk_tbl[1], 1, "bp_r1");
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = '0;
    acc = 0;
    repeat (6) begin
      if (in_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_accepted", 128'(acc), 128'(STALL_ACC));
    check("bp_rdy", 128'(in_ready), 128'(0));
    check("bp_vld", 128'(out_valid), 128'(1));
    check("bp_hold_dat", out_data, rk_tbl[2]);
    check("bp_hold_rnd", 128'(out_round), 128'(2));
    out_ready = 1'b1;
    for (int k = 0; k < STALL_ACC; k++) begin
      check($sformatf("drain%0d_vld", k), 128'(out_valid), 128'(1));
      check($sformatf("drain%0d_dat", k), out_data, rk_tbl[2 + k]);
      check($sformatf("drain%0d_rnd", k), 128'(out_round), 128'(2 + k));
      @(posedge clk);
      @(negedge clk);
    end
    check("drain_empty", 128'(out_valid), 128'(0));
    nxt = 2 + STALL_ACC;
    while (nxt < 4) begin
      xfer('0, rk_tbl[nxt], nxt, $sformatf("pre_kl_r%0d", nxt));
      nxt++;
    end

    // key_load collides with in_valid at round 4, with a held output pending
    out_ready = 1'b0;
    key_load  = 1'b1;
    key_in    = KEY_B;
    in_valid  = 1'b1;
    in_data   = '0;
    #1 check("kl_rdy", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1 begin
      key_load = 1'b0;
      in_valid = 1'b0;
    end
    @(negedge clk);
    check("kl_vld_drop", 128'(out_valid), 128'(0));
    out_ready = 1'b1;
    check("kl_rdy_after", 128'(in_ready), 128'(1));
    xfer(128'h00112233445566778899aabbccddeeff, 128'h00102030405060708090a0b0c0d0e0f0, 0, "kb_r0");
    xfer('0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 1, "kb_r1");

    // One-cycle reset mid-sequence
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero_outputs("midrst");
    in_valid = 1'b1;
    @(negedge clk);
    check("midrst_rdy_hold", 128'(in_ready), 128'(0));
    check("midrst_vld_hold", 128'(out_valid), 128'(0));
    in_valid = 1'b0;
    load_key(KEY_A);
    xfer(128'h3243f6a8885a308d313198a2e0370734, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
